// File: rtl/time_set_ctrl.sv
// Button-driven HH:MM:SS editor: select walks hours -> minutes -> seconds -> commit,
// up/down step the active field with auto-repeat, idle edits time out and are discarded.
module time_set_ctrl #(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned TIMEOUT      = 10000,
  parameter int unsigned BLINK_HALF   = 250
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_sel_i,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  output logic [4:0] set_hrs_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       load_o,
  output logic [4:0] edit_hrs_o,
  output logic [5:0] edit_min_o,
  output logic [5:0] edit_sec_o,
  output logic       editing_o,
  output logic [1:0] field_o,
  output logic       blink_o
);

  localparam int unsigned RepW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
  localparam int unsigned BlkW = $clog2(BLINK_HALF + 1);

  typedef enum logic [2:0] {StIdle, StEditH, StEditM, StEditS, StCommit} state_e;

  state_e          state_q, state_d;
  logic [2:0]      btn_q, btn_d;
  logic [4:0]      set_hrs_q, set_hrs_d, edit_hrs_q, edit_hrs_d;
  logic [5:0]      set_min_q, set_min_d, edit_min_q, edit_min_d;
  logic [5:0]      set_sec_q, set_sec_d, edit_sec_q, edit_sec_d;
  logic [RepW-1:0] rep_q, rep_d, rep_inc;
  logic [ToW-1:0]  to_q, to_d, to_inc;
  logic [BlkW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic            blink_q, blink_d;

  logic sel_edge, up_edge, dn_edge, up_alone, dn_alone;
  logic in_edit, do_step, rep_fire, activity;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  always_comb begin
    btn_d    = {btn_sel_i, btn_up_i, btn_dn_i};
    sel_edge = btn_sel_i & ~btn_q[2];
    up_edge  = btn_up_i & ~btn_q[1];
    dn_edge  = btn_dn_i & ~btn_q[0];
    up_alone = btn_up_i & ~btn_dn_i;
    dn_alone = btn_dn_i & ~btn_up_i;
    in_edit  = (state_q == StEditH) || (state_q == StEditM) || (state_q == StEditS);

    state_d    = state_q;
    set_hrs_d  = set_hrs_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    edit_hrs_d = edit_hrs_q;
    edit_min_d = edit_min_q;
    edit_sec_d = edit_sec_q;
    rep_d      = '0;
    to_d       = '0;
    blink_d    = 1'b0;
    bcnt_d     = '0;
    do_step    = 1'b0;
    rep_fire   = 1'b0;
    rep_inc    = rep_q + RepW'(1);
    to_inc     = to_q + ToW'(1);
    bcnt_inc   = bcnt_q + BlkW'(1);

    // Repeat counter runs only while exactly one step button is held in an edit field.
    if (in_edit && !sel_edge && (up_alone || dn_alone)) begin
      if ((up_alone && up_edge) || (dn_alone && dn_edge)) begin
        do_step = 1'b1;
      end else if (rep_inc == RepW'(REPEAT_DELAY)) begin
        do_step  = 1'b1;
        rep_fire = 1'b1;
        rep_d    = RepW'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        rep_d = rep_inc;
      end
    end
    activity = sel_edge | up_edge | dn_edge | rep_fire;

    unique case (state_q)
      StIdle: begin
        edit_hrs_d = set_hrs_q;
        edit_min_d = set_min_q;
        edit_sec_d = set_sec_q;
        if (sel_edge) begin
          state_d = StEditH;
          blink_d = 1'b1;
        end
      end
      StEditH, StEditM, StEditS: begin
        if (sel_edge) begin
          blink_d = 1'b1;
          unique case (state_q)
            StEditH: state_d = StEditM;
            StEditM: state_d = StEditS;
            default: begin
              state_d   = StCommit;
              blink_d   = 1'b0;
              set_hrs_d = edit_hrs_q;
              set_min_d = edit_min_q;
              set_sec_d = edit_sec_q;
            end
          endcase
        end else if (!activity && (to_inc == ToW'(TIMEOUT))) begin
          state_d    = StIdle;
          edit_hrs_d = set_hrs_q;
          edit_min_d = set_min_q;
          edit_sec_d = set_sec_q;
        end else begin
          if (!activity) to_d = to_inc;
          if (bcnt_inc == BlkW'(BLINK_HALF)) begin
            blink_d = ~blink_q;
          end else begin
            blink_d = blink_q;
            bcnt_d  = bcnt_inc;
          end
          if (do_step) begin
            unique case (state_q)
              StEditH: edit_hrs_d = 5'(wrap_step({1'b0, edit_hrs_q}, 6'd23, up_alone));
              StEditM: edit_min_d = wrap_step(edit_min_q, 6'd59, up_alone);
              default: edit_sec_d = wrap_step(edit_sec_q, 6'd59, up_alone);
            endcase
          end
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      btn_q      <= '0;
      set_hrs_q  <= '0;
      set_min_q  <= '0;
      set_sec_q  <= '0;
      edit_hrs_q <= '0;
      edit_min_q <= '0;
      edit_sec_q <= '0;
      rep_q      <= '0;
      to_q       <= '0;
      bcnt_q     <= '0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_d;
      set_hrs_q  <= set_hrs_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
      edit_hrs_q <= edit_hrs_d;
      edit_min_q <= edit_min_d;
      edit_sec_q <= edit_sec_d;
      rep_q      <= rep_d;
      to_q       <= to_d;
      bcnt_q     <= bcnt_d;
      blink_q    <= blink_d;
    end
  end

  always_comb begin
    set_hrs_o  = set_hrs_q;
    set_min_o  = set_min_q;
    set_sec_o  = set_sec_q;
    edit_hrs_o = edit_hrs_q;
    edit_min_o = edit_min_q;
    edit_sec_o = edit_sec_q;
    load_o     = (state_q == StCommit);
    editing_o  = in_edit;
    blink_o    = blink_q;
    unique case (state_q)
      StEditH: field_o = 2'd1;
      StEditM: field_o = 2'd2;
      StEditS: field_o = 2'd3;
      default: field_o = 2'd0;
    endcase
  end

endmodule
